// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter:
// requester count, index width, FSM state encoding and a one-hot helper.
package mux_arb_pkg;

  localparam int NUM_REQ  = 8;
  localparam int IDX_BITS = 3;

  // IDLE: nobody owns the mux. GRANT: one requester owns it.
  // RELEASE: the single dead cycle between two grants.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arbState_t;

  // Turn a requester index into its grant bit.
  function automatic logic [NUM_REQ-1:0] oneHot(input logic [IDX_BITS-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational round-robin picker. Starting just after the most recent
// owner and wrapping around, the first requester with its REQ bit set wins.
// The most recent owner itself is looked at last, so it can only win again
// when nobody else is asking.
module rr_pick_8
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0]  REQ,
  input  logic [IDX_BITS-1:0] LAST,
  output logic [IDX_BITS-1:0] WIN,
  output logic                FOUND
);

  logic [IDX_BITS-1:0] cand;

  // Walk LAST+1 .. LAST+8 (mod 8) and latch the first requester found; the
  // 3-bit add wraps naturally, and offset 8 lands back on LAST itself.
  always_comb begin
    WIN   = '0;
    FOUND = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = LAST + IDX_BITS'(k);
      if (!FOUND && REQ[cand]) begin
        WIN   = cand;
        FOUND = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_8x1_arbiter.sv
// Round-robin arbiter for a shared 8:1 data mux. SEL drives the mux select
// directly and GNT tells each requester whether it currently owns the mux.
// A grant lasts until the owner raises DONE, drops its request, or the
// watchdog runs out; every grant is followed by one dead cycle with GNT=0
// so that the mux never switches while someone believes they own it.
module mux_8x1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned CNT_BITS = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_REQ-1:0]  REQ,
  input  logic                DONE,
  output logic [IDX_BITS-1:0] SEL,
  output logic [NUM_REQ-1:0]  GNT,
  output logic                BUSY,
  output logic                TIMEOUT_ERR
);

  // Watchdog limit in counter width; a limit of zero switches the watchdog off.
  localparam logic [CNT_BITS-1:0] TimeoutCnt = CNT_BITS'(TIMEOUT);
  localparam logic [CNT_BITS-1:0] CountMax   = '1;
  localparam logic [CNT_BITS-1:0] CountOne   = CNT_BITS'(1);
  localparam bit                  WdEnable   = (TIMEOUT != 0);

  arbState_t            state_q;
  logic [IDX_BITS-1:0]  sel_q;
  logic [IDX_BITS-1:0]  last_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 busy_q;
  logic                 timeoutErr_q;
  logic [CNT_BITS-1:0]  count_q;
  logic [CNT_BITS-1:0]  count_d;

  logic [IDX_BITS-1:0]  pickWin;
  logic                 pickFound;
  logic                 ownerReq;
  logic                 wdExpired;
  logic                 releaseNow;
  logic                 timeoutHit;

  // The picker is consulted in IDLE and RELEASE; last_q is already updated
  // to the outgoing owner by the time RELEASE evaluates it.
  rr_pick_8 uRrPick (
    .REQ   (REQ),
    .LAST  (last_q),
    .WIN   (pickWin),
    .FOUND (pickFound)
  );

  // Grant-length bookkeeping: release causes and a saturating count that
  // never wraps back below the watchdog limit on very long grants.
  always_comb begin
    ownerReq   = REQ[sel_q];
    wdExpired  = WdEnable && (count_q == TimeoutCnt);
    releaseNow = DONE || !ownerReq || wdExpired;
    timeoutHit = wdExpired && !DONE && ownerReq;
    count_d    = (count_q == CountMax) ? count_q : count_q + CountOne;
  end

  // Arbitration FSM; every output is a register written only here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_q       <= '1;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
      count_q      <= '0;
    end else begin
      timeoutErr_q <= 1'b0;
      case (state_q)
        IDLE, RELEASE: begin
          if (pickFound) begin
            sel_q   <= pickWin;
            gnt_q   <= oneHot(pickWin);
            count_q <= CountOne;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end else begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (releaseNow) begin
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            last_q       <= sel_q;
            timeoutErr_q <= timeoutHit;
            state_q      <= RELEASE;
          end else begin
            count_q <= count_d;
          end
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SEL         = sel_q;
  assign GNT         = gnt_q;
  assign BUSY        = busy_q;
  assign TIMEOUT_ERR = timeoutErr_q;

endmodule

// File: doc/mux_8x1_arbiter.md
# mux_8x1_arbiter

Round-robin arbiter that shares one 8:1 data multiplexer among eight requesters. Registers the mux select code and a one-hot grant, holds the grant until the owner signals completion, withdraws, or the watchdog expires, then inserts one dead cycle before re-arbitrating. Sits beside the 8-input mux: its SEL output drives the mux select directly; requesters drive the mux data inputs and watch their GNT bit.

## Interface
- TIMEOUT, default 15: maximum grant length in cycles; 0 disables the watchdog.
- CNT_BITS, default 8: watchdog counter width; TIMEOUT < 2^CNT_BITS.

- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- REQ  in  8  request vector, bit i = requester i (i drives mux input Di).
- DONE  in  1  owner finished; sampled only in GRANT.
- SEL  out  3  registered mux select, binary index of current/last owner.
- GNT  out  8  registered one-hot grant; all-zero when nobody owns the mux.
- BUSY  out  1  1 while in GRANT.
- TIMEOUT_ERR  out  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- States: IDLE, GRANT, RELEASE (encoded in shared package).
- Round-robin pointer LAST (3 bits): index of most recent owner. Search order LAST+1, LAST+2, … LAST+8 mod 8; first set REQ bit wins.
- IDLE: if REQ != 0 → pick winner W; SEL←W, GNT←one-hot(W), count←1, go GRANT. Else stay; SEL holds.
- GRANT: release condition = DONE | ~REQ[SEL] | (TIMEOUT != 0 & count == TIMEOUT). On release: GNT←0, LAST←SEL, go RELEASE; TIMEOUT_ERR←1 only if released by watchdog with DONE=0 and REQ[SEL]=1. Otherwise count←count+1 (saturating at 2^CNT_BITS-1).
- RELEASE: GNT=0 for exactly this cycle. If REQ != 0 → arbitrate as in IDLE (using updated LAST), go GRANT; else go IDLE.
- SEL changes only on the edge entering GRANT; never changes while GNT != 0.
- Priority of simultaneous release causes: DONE > withdraw > timeout (err only for pure timeout).
- DONE outside GRANT ignored. REQ changes of non-owners during GRANT ignored.
- Owner re-requesting immediately is allowed but has lowest priority at the next arbitration.

## Timing
- Reset (async assert, sync-safe release): state IDLE, SEL=0, GNT=0, BUSY=0, TIMEOUT_ERR=0, count=0, LAST=7 (requester 0 has first priority).
- Reset mid-grant: GNT, BUSY drop immediately (asynchronously); no TIMEOUT_ERR.
- Grant latency: REQ high before edge k in IDLE → GNT/SEL valid after edge k (1 cycle).
- Grant length: DONE high at edge j of GRANT → GNT low after edge j; minimum grant = 1 cycle.
- Back-to-back: inter-grant gap exactly 1 cycle (RELEASE) when requests pending.
- Watchdog: with DONE never asserted, GNT high for exactly TIMEOUT cycles; TIMEOUT_ERR high during the RELEASE cycle.
- All outputs registered; no combinational input-to-output paths.

## Structure
- Package mux_arb_pkg: NUM_REQ=8, IDX_BITS=3, state encodings IDLE/GRANT/RELEASE.
- Sub-module rr_pick_8 (combinational): inputs REQ[7:0], LAST[2:0]; outputs WIN[2:0], FOUND. Used in IDLE and RELEASE.
- Block does not instantiate the mux; integration wires SEL to the mux select.

## Test plan
- Reset: reset_n=0 mid-run → SEL=0, GNT=0, BUSY=0, TIMEOUT_ERR=0 immediately; after release with REQ=8'h01 → GNT=8'h01, SEL=0 one cycle later.
- Round robin: REQ=8'hFF held, DONE pulsed on every grant's 1st cycle → grant order 0,1,2,…,7,0 with one GNT=0 cycle between each.
- Rotation from pointer: after owner 5 releases, REQ=8'h21 (bits 0,5) → next grant is 0, then 5.
- Watchdog: TIMEOUT=15, REQ=8'h08, DONE=0 → GNT=8'h08 for 15 cycles, then GNT=0 and TIMEOUT_ERR=1 for one cycle; SEL=3 throughout.
- Simultaneous: DONE=1 at count==TIMEOUT → release, TIMEOUT_ERR stays 0; withdraw (REQ[SEL]→0) mid-grant → release next edge, no error.
- Stability: non-owner REQ toggling during GRANT → SEL and GNT unchanged until release; TIMEOUT=0 with DONE=0 → grant held indefinitely (check 300 cycles).
